// File: rtl/store_buffer.sv
// Committed-store buffer: DEPTH-entry FIFO drained over a request/done store channel,
// with word-granular load hazard detection against every pending entry.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  logic [31:0] push_address_i,
  input  logic [31:0] push_data_i,
  input  logic [1:0]  push_width_i,
  output logic        full_o,
  output logic        empty_o,
  input  logic [31:0] load_address_i,
  output logic        load_hazard_o,
  output logic        str_request_o,
  output logic [31:0] str_address_o,
  output logic [31:0] str_data_o,
  output logic [1:0]  str_width_o,
  input  logic        str_done_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_DONE = 1'b1} state_t;

  logic [31:0]      addr_mem_r [DEPTH];
  logic [31:0]      data_mem_r [DEPTH];
  logic [1:0]       width_mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  state_t           state_r;
  state_t           state_next_s;
  logic             push_accept_s;
  logic             pop_s;
  logic             start_s;
  logic [DEPTH-1:0] valid_s;

  assign full_o        = (count_r == CW'(DEPTH));
  assign empty_o       = (count_r == {CW{1'b0}});
  assign push_accept_s = push_i & ~full_o;

  // Entry storage and pointer/count bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i]  <= 32'h0000_0000;
        data_mem_r[i]  <= 32'h0000_0000;
        width_mem_r[i] <= 2'd0;
      end
    end else begin
      if (push_accept_s) begin
        addr_mem_r[wr_ptr_r]  <= push_address_i;
        data_mem_r[wr_ptr_r]  <= push_data_i;
        width_mem_r[wr_ptr_r] <= push_width_i;
        wr_ptr_r              <= wr_ptr_r + AW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != {CW{1'b0}}) state_next_s = WAIT_DONE;
        else                       state_next_s = IDLE;
      end
      WAIT_DONE: begin
        if (str_done_i) state_next_s = IDLE;
        else            state_next_s = WAIT_DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Drain FSM decoded controls; done only matters while a request is outstanding.
  always_comb begin
    start_s = 1'b0;
    pop_s   = 1'b0;
    case (state_r)
      IDLE:      start_s = (count_r != {CW{1'b0}});
      WAIT_DONE: pop_s   = str_done_i;
      default: begin
        start_s = 1'b0;
        pop_s   = 1'b0;
      end
    endcase
  end

  // Store channel outputs, launched from the head entry and held until done.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      str_request_o <= 1'b0;
      str_address_o <= 32'h0000_0000;
      str_data_o    <= 32'h0000_0000;
      str_width_o   <= 2'd0;
    end else if (start_s) begin
      str_request_o <= 1'b1;
      str_address_o <= addr_mem_r[rd_ptr_r];
      str_data_o    <= data_mem_r[rd_ptr_r];
      str_width_o   <= width_mem_r[rd_ptr_r];
    end else begin
      str_request_o <= 1'b0;
      str_address_o <= str_address_o;
      str_data_o    <= str_data_o;
      str_width_o   <= str_width_o;
    end
  end

  // Hazard: slot i is valid when its distance from the read pointer is below count.
  always_comb begin
    valid_s       = {DEPTH{1'b0}};
    load_hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i]    = ({1'b0, AW'(i) - rd_ptr_r} < count_r);
      load_hazard_o = load_hazard_o |
                      (valid_s[i] & (addr_mem_r[i][31:2] == load_address_i[31:2]));
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the buffer and its store channel.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        push_i = 1'b0;
  logic [31:0] push_address_i = 32'h0;
  logic [31:0] push_data_i = 32'h0;
  logic [1:0]  push_width_i = 2'd0;
  logic        full_o;
  logic        empty_o;
  logic [31:0] load_address_i = 32'h0;
  logic        load_hazard_o;
  logic        str_request_o;
  logic [31:0] str_address_o;
  logic [31:0] str_data_o;
  logic [1:0]  str_width_o;
  logic        str_done_i = 1'b0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .push_i(push_i), .push_address_i(push_address_i),
    .push_data_i(push_data_i), .push_width_i(push_width_i), .full_o(full_o), .empty_o(empty_o),
    .load_address_i(load_address_i), .load_hazard_o(load_hazard_o),
    .str_request_o(str_request_o), .str_address_o(str_address_o), .str_data_o(str_data_o),
    .str_width_o(str_width_o), .str_done_i(str_done_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [1:0] w; } ent_t;

  // Reference model: pending stores in order, plus whether the head is on the channel.
  ent_t        q[$];
  bit          in_flight;
  logic        exp_req;
  logic [31:0] exp_addr, exp_data;
  logic [1:0]  exp_width;
  int          checks = 0;
  int          errors = 0;

  function automatic bit model_hazard(input logic [31:0] la);
    foreach (q[i]) if (q[i].a[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, cross the edge, advance the model, settle.
  task automatic cycle(input bit push, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w, input bit done);
    bit acc, pop, start;
    ent_t head;
    acc   = push && (q.size() < DEPTH);
    pop   = in_flight && done;
    start = !in_flight && (q.size() > 0);
    if (start) head = q[0];
    push_i = push; push_address_i = a; push_data_i = d; push_width_i = w; str_done_i = done;
    @(posedge clk_i);
    if (!rst_n_i) begin
      q.delete(); in_flight = 0;
      exp_req = 0; exp_addr = 0; exp_data = 0; exp_width = 0;
    end else begin
      exp_req = start;
      if (start) begin
        in_flight = 1; exp_addr = head.a; exp_data = head.d; exp_width = head.w;
      end
      if (pop) begin
        void'(q.pop_front());
        in_flight = 0;
      end
      if (acc) q.push_back('{a: a, d: d, w: w});
    end
    #1;
    push_i = 1'b0; str_done_i = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    idle();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    load_address_i = 32'h0;
    do_reset();
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    checks++; if (str_request_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", str_request_o); end
    checks++; if ({str_address_o, str_data_o, str_width_o} !== 66'h0) begin errors++;
      $display("FAIL reset_chan: got %h/%h/%h want 0", str_address_o, str_data_o, str_width_o); end
    checks++; if (load_hazard_o !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", load_hazard_o); end
  endtask

  task automatic test_single_store();
    do_reset();
    cycle(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2'd2, 1'b0);
    checks++; if (empty_o !== 1'b0 || str_request_o !== 1'b0) begin errors++;
      $display("FAIL single_push: empty=%b req=%b want 0/0", empty_o, str_request_o); end
    idle();
    checks++; if ({str_request_o, str_address_o, str_data_o, str_width_o} !== {1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2'd2}) begin
      errors++; $display("FAIL single_req: got %b %h %h %0d want 1 00001004 deadbeef 2",
                         str_request_o, str_address_o, str_data_o, str_width_o); end
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++; if ({str_request_o, str_address_o, str_data_o, str_width_o} !== {1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 2'd2}) begin
        errors++; $display("FAIL single_hold: got %b %h %h %0d want 0 00001004 deadbeef 2",
                           str_request_o, str_address_o, str_data_o, str_width_o); end
    end
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty_o); end
    idle();
    checks++; if (str_request_o !== 1'b0) begin errors++; $display("FAIL single_noreq: got %b want 0", str_request_o); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 32'((k + 1) * 16), 32'hA0 + 32'(k), 2'd2, 1'b0);
      checks++; if (full_o !== (k >= 3)) begin errors++;
        $display("FAIL fill_full: push %0d got %b want %b", k, full_o, (k >= 3)); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (str_address_o !== 32'((k + 1) * 16)) begin errors++;
        $display("FAIL fill_order: entry %0d got %h want %h", k, str_address_o, 32'((k + 1) * 16)); end
      cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      if (k < 3) begin
        idle();
        checks++; if (str_request_o !== 1'b1) begin errors++;
          $display("FAIL fill_req: entry %0d got %b want 1", k + 1, str_request_o); end
      end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fill_drop: empty got %b want 1", empty_o); end
    idle();
    checks++; if (str_request_o !== 1'b0) begin errors++; $display("FAIL fill_extra_req: got %b want 0", str_request_o); end
  endtask

  task automatic test_wrap();
    int pushed;
    do_reset();
    cycle(1'b1, 32'h200, 32'h1, 2'd2, 1'b0);
    cycle(1'b1, 32'h204, 32'h2, 2'd1, 1'b0);
    cycle(1'b1, 32'h208, 32'h3, 2'd0, 1'b1);
    checks++; if (full_o !== 1'b0 || empty_o !== 1'b0) begin errors++;
      $display("FAIL wrap_pushpop: full=%b empty=%b want 0/0", full_o, empty_o); end
    cycle(1'b1, 32'h20C, 32'h4, 2'd2, 1'b0);
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL wrap_count3: full got %b want 0", full_o); end
    cycle(1'b1, 32'h210, 32'h5, 2'd2, 1'b0);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL wrap_count4: full got %b want 1", full_o); end
    pushed = 5;
    for (int c = 0; c < 200 && !(pushed == 10 && q.size() == 0 && !in_flight); c++) begin
      bit p, dn;
      logic [31:0] a;
      p  = (pushed < 10) && ($urandom_range(0, 1) == 1);
      dn = in_flight && ($urandom_range(0, 1) == 1);
      a  = 32'h300 + 32'(pushed * 4);
      if (p && q.size() < DEPTH) pushed++;
      cycle(p, a, a ^ 32'h5A5A_0000, 2'd2, dn);
      checks++; if (str_request_o !== exp_req) begin errors++;
        $display("FAIL wrap_req: got %b want %b", str_request_o, exp_req); end
      if (exp_req) begin
        checks++; if (str_address_o !== exp_addr || str_data_o !== exp_data) begin errors++;
          $display("FAIL wrap_order: got %h/%h want %h/%h", str_address_o, str_data_o, exp_addr, exp_data); end
      end
    end
    checks++; if (!(pushed == 10 && q.size() == 0) || empty_o !== 1'b1) begin errors++;
      $display("FAIL wrap_done: pushed=%0d left=%0d empty=%b want 10/0/1", pushed, q.size(), empty_o); end
  endtask

  task automatic test_hazard();
    do_reset();
    load_address_i = 32'h0000_2000;
    cycle(1'b1, 32'h0000_2002, 32'h55, 2'd0, 1'b0);
    checks++; if (load_hazard_o !== 1'b1) begin errors++; $display("FAIL hazard_hit: got %b want 1", load_hazard_o); end
    load_address_i = 32'h0000_2004; #1;
    checks++; if (load_hazard_o !== 1'b0) begin errors++; $display("FAIL hazard_miss: got %b want 0", load_hazard_o); end
    load_address_i = 32'h0000_2000;
    idle();
    checks++; if (load_hazard_o !== 1'b1 || str_request_o !== 1'b1) begin errors++;
      $display("FAIL hazard_inflight: hazard=%b req=%b want 1/1", load_hazard_o, str_request_o); end
    idle();
    str_done_i = 1'b1; #1;
    checks++; if (load_hazard_o !== 1'b1) begin errors++; $display("FAIL hazard_done_cycle: got %b want 1", load_hazard_o); end
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    checks++; if (load_hazard_o !== 1'b0) begin errors++; $display("FAIL hazard_after_done: got %b want 0", load_hazard_o); end
    load_address_i = 32'h0000_3000;
    push_i = 1'b1; push_address_i = 32'h0000_3000; #1;
    checks++; if (load_hazard_o !== 1'b0) begin errors++; $display("FAIL hazard_same_cycle_push: got %b want 0", load_hazard_o); end
    cycle(1'b1, 32'h0000_3000, 32'h66, 2'd2, 1'b0);
    checks++; if (load_hazard_o !== 1'b1) begin errors++; $display("FAIL hazard_next_cycle: got %b want 1", load_hazard_o); end
  endtask

  task automatic test_full_push_pop();
    int reqs;
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h400 + 32'(k * 4), 32'(k), 2'd2, 1'b0);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b want 1", full_o); end
    cycle(1'b1, 32'h0000_04F0, 32'h0000_0BAD, 2'd2, 1'b1);
    checks++; if (full_o !== 1'b0 || empty_o !== 1'b0) begin errors++;
      $display("FAIL fpp_count3: full=%b empty=%b want 0/0", full_o, empty_o); end
    reqs = 0;
    for (int c = 0; c < 20 && (q.size() > 0 || in_flight); c++) begin
      cycle(1'b0, 32'h0, 32'h0, 2'd0, in_flight);
      if (str_request_o === 1'b1) begin
        reqs++;
        checks++; if (str_address_o === 32'h0000_04F0 || str_address_o !== exp_addr) begin errors++;
          $display("FAIL fpp_order: got %h want %h", str_address_o, exp_addr); end
      end
    end
    checks++; if (reqs !== 3 || empty_o !== 1'b1) begin errors++;
      $display("FAIL fpp_drain: requests=%0d empty=%b want 3/1", reqs, empty_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_address_i = 32'h0000_0500;
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h500 + 32'(k * 4), 32'h77 + 32'(k), 2'd1, 1'b0);
    checks++; if (load_hazard_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_hazard: got %b want 1", load_hazard_o); end
    do_reset();
    checks++; if ({str_request_o, str_address_o, str_data_o, str_width_o} !== 67'h0) begin errors++;
      $display("FAIL rmid_chan: got %b %h %h %0d want all 0", str_request_o, str_address_o, str_data_o, str_width_o); end
    checks++; if (full_o !== 1'b0 || empty_o !== 1'b1 || load_hazard_o !== 1'b0) begin errors++;
      $display("FAIL rmid_flags: full=%b empty=%b hazard=%b want 0/1/0", full_o, empty_o, load_hazard_o); end
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      idle();
      checks++; if (str_request_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0) begin errors++;
        $display("FAIL rmid_after: req=%b empty=%b full=%b want 0/1/0", str_request_o, empty_o, full_o); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a;
      a = 32'h0000_1000 | 32'($urandom_range(0, 15) << 1);
      load_address_i = 32'h0000_1000 | 32'($urandom_range(0, 15) << 1);
      cycle($urandom_range(0, 2) != 0, a, $urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 2) == 0);
      checks++; if (str_request_o !== exp_req) begin errors++;
        $display("FAIL rand_req: cycle %0d got %b want %b", c, str_request_o, exp_req); end
      checks++; if (full_o !== (q.size() == DEPTH) || empty_o !== (q.size() == 0)) begin errors++;
        $display("FAIL rand_flags: cycle %0d full=%b empty=%b want size %0d", c, full_o, empty_o, q.size()); end
      checks++; if (load_hazard_o !== model_hazard(load_address_i)) begin errors++;
        $display("FAIL rand_hazard: cycle %0d got %b want %b", c, load_hazard_o, model_hazard(load_address_i)); end
      if (in_flight) begin
        checks++; if (str_address_o !== exp_addr || str_data_o !== exp_data || str_width_o !== exp_width) begin errors++;
          $display("FAIL rand_chan: cycle %0d got %h/%h/%0d want %h/%h/%0d", c, str_address_o, str_data_o,
                   str_width_o, exp_addr, exp_data, exp_width); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_store();
    test_fill_overflow();
    test_wrap();
    test_hazard();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
